codec_cfg_seq: RTL and testbench

CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

---
 rtl/codec_cfg_seq.sv | 154 +++++++++++++++
 tb/tb_codec_cfg_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: walks a register table and hands each word
// to an SPI writer with power-up, gap, delay and timeout timing.
module codec_cfg_seq #(
  parameter int NUM_WORDS      = 12,
  parameter int PWRUP_CYCLES   = 1000,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  rom_addr,
  input  logic [14:0] rom_data,
  output logic [14:0] data_tx,
  output logic        req,
  input  logic        done,
  output logic        busy,
  output logic        cfg_done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_LATCH, S_REQ,
    S_WAIT, S_GAP, S_DELAY, S_FIN, S_ERR
  } state_e;

  localparam logic [15:0] PWR_LAST =
    (PWRUP_CYCLES > 0) ? 16'(PWRUP_CYCLES - 1) : 16'd0;
  localparam logic [15:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [15:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [4:0] IDX_LAST = 5'(NUM_WORDS - 1);

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [15:0] cnt_q;
  logic [7:0]  dly_q;
  logic [4:0]  rom_addr_q;
  logic [14:0] data_tx_q;
  logic        req_q;
  logic        busy_q;
  logic        cfg_done_q;
  logic        err_q;

  logic [15:0] cnt_d;
  logic [4:0]  idx_d;
  logic [15:0] dly_len;
  logic        last_w;
  logic        dly_w;

  // Saturating increment shared by every timed state
  assign cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign idx_d   = idx_q + 5'd1;
  assign last_w  = (idx_q >= IDX_LAST);
  assign dly_w   = (rom_data[14:8] == 7'h7F);
  assign dly_len = {dly_q, 8'h00};

  // Sequencer FSM with all outputs held in registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 5'd0;
      cnt_q      <= 16'd0;
      dly_q      <= 8'd0;
      rom_addr_q <= 5'd0;
      data_tx_q  <= 15'd0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_PWRUP;
            idx_q      <= 5'd0;
            cnt_q      <= 16'd0;
            rom_addr_q <= 5'd0;
            busy_q     <= 1'b1;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        S_PWRUP: begin
          if (cnt_q >= PWR_LAST) begin
            state_q    <= S_FETCH;
            cnt_q      <= 16'd0;
            rom_addr_q <= idx_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          dly_q <= rom_data[7:0];
          cnt_q <= 16'd0;
          if (dly_w) begin
            state_q <= S_DELAY;
          end else begin
            data_tx_q <= rom_data;
            req_q     <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          req_q   <= 1'b0;
          cnt_q   <= cnt_d;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            state_q <= S_GAP;
            cnt_q   <= 16'd0;
          end else if (cnt_q >= TMO_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP, S_DELAY: begin
          if ((state_q == S_GAP && cnt_q >= GAP_LAST) ||
              (state_q == S_DELAY && cnt_d >= dly_len)) begin
            cnt_q <= 16'd0;
            if (last_w) begin
              state_q    <= S_FIN;
              cfg_done_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q    <= S_FETCH;
              idx_q      <= idx_d;
              rom_addr_q <= idx_d;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign data_tx  = data_tx_q;
  assign req      = req_q;
  assign busy     = busy_q;
  assign cfg_done = cfg_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: timeline model of the table sequencer,
// randomized tables and done latencies, per-scenario tasks.
module tb_codec_cfg_seq;

  localparam int NW  = 3;
  localparam int PWR = 10;
  localparam int GAP = 16;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done = 1'b0;
  logic [4:0]  rom_addr;
  logic [14:0] rom_data = 15'd0;
  logic [14:0] data_tx;
  logic        req, busy, cfg_done, err;

  logic [14:0] rom [0:31];

  int cyc = 0;
  int start_at = -100, start_at2 = -100;
  int xdone_at = -100, done_at = -100;
  int lat = 40, hold_ord = -1, base_n = 0;

  int          rq_cyc [$];
  logic [14:0] rq_dat [$];
  int   hold_err = 0, dbl_err = 0, busy_fall = -1;
  logic req_p = 1'b0, busy_p = 1'b0, infl = 1'b0;
  logic [14:0] hv = 15'd0;

  int          exp_c [$];
  logic [14:0] exp_d [$];
  int exp_end = 0;
  logic exp_er = 1'b0;
  int h0 = 0, d0 = 0;

  int n_asrt = 0, n_fail = 0;

  codec_cfg_seq #(
    .NUM_WORDS(NW), .PWRUP_CYCLES(PWR),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .data_tx(data_tx), .req(req), .done(done),
    .busy(busy), .cfg_done(cfg_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Table memory with one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  // start and done pulses land on the scheduled edges
  always @(posedge clk) begin
    #1;
    start <= (cyc + 1 == start_at) || (cyc + 1 == start_at2);
    done  <= (cyc + 1 == done_at) || (cyc + 1 == xdone_at);
  end

  // Observe req pulses, answer them, watch data_tx hold
  always @(negedge clk) begin
    if (req) begin
      if (req_p) dbl_err <= dbl_err + 1;
      else begin
        rq_cyc.push_back(cyc);
        rq_dat.push_back(data_tx);
        if (rq_cyc.size() - 1 - base_n != hold_ord)
          done_at <= cyc + lat;
        hv   <= data_tx;
        infl <= 1'b1;
      end
    end else if (infl) begin
      if (data_tx !== hv) hold_err <= hold_err + 1;
      if (done) infl <= 1'b0;
    end
    if (!rst) infl <= 1'b0;
    if (!busy && busy_p) busy_fall <= cyc;
    req_p  <= req;
    busy_p <= busy;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time %0t reached, limit 600000", $time);
    $fatal(1);
  end

  task automatic load_std();
    for (int i = 0; i < 32; i++) rom[i] = 15'd0;
    rom[0] = 15'h0123;
    rom[1] = 15'h0A55;
    rom[2] = 15'h1FFF;
  endtask

  // Timeline of one sequence: when each req appears,
  // what it carries, and when busy drops.
  task automatic model(input int st);
    int lx, c, n;
    logic [14:0] w;
    exp_c.delete();
    exp_d.delete();
    exp_er  = 1'b0;
    exp_end = st;
    lx = st + PWR + 2;
    for (int i = 0; i < NW; i++) begin
      w = rom[i];
      if (w[14:8] == 7'h7F) begin
        n = int'(w[7:0]) * 256;
        c = lx + ((n == 0) ? 1 : n);
      end else begin
        exp_c.push_back(lx);
        exp_d.push_back(w);
        if (exp_c.size() - 1 == hold_ord) begin
          exp_end = lx + TMO;
          exp_er  = 1'b1;
          return;
        end
        c = lx + lat + GAP;
      end
      if (i == NW - 1) exp_end = c;
      else lx = c + 2;
    end
  endtask

  task automatic launch();
    @(posedge clk);
    #2;
    base_n   = rq_cyc.size();
    h0       = hold_err;
    d0       = dbl_err;
    start_at = cyc + 2;
    model(start_at);
  endtask

  task automatic settle();
    while (cyc < exp_end + 8) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_asrt++; if (rom_addr !== 5'd0) begin n_fail++;
      $display("FAIL rst_rom_addr: got %0h want 0", rom_addr); end
    n_asrt++; if (data_tx !== 15'd0) begin n_fail++;
      $display("FAIL rst_data_tx: got %0h want 0", data_tx); end
    n_asrt++; if (req !== 1'b0) begin n_fail++;
      $display("FAIL rst_req: got %b want 0", req); end
    n_asrt++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    n_asrt++; if (cfg_done !== 1'b0) begin n_fail++;
      $display("FAIL rst_cfg_done: got %b want 0", cfg_done); end
    n_asrt++; if (err !== 1'b0) begin n_fail++;
      $display("FAIL rst_err: got %b want 0", err); end
    @(negedge clk) rst = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    n_asrt++; if (busy !== 1'b0 || rq_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_start: busy %b reqs %0d want 0 0",
               busy, rq_cyc.size()); end
  endtask

  task automatic test_spec_seq();
    load_std();
    lat = 40;
    hold_ord = -1;
    launch();
    settle();
    n_asrt++; if (rq_cyc.size() - base_n != exp_c.size()) begin
      n_fail++;
      $display("FAIL seq_count: got %0d want %0d",
               rq_cyc.size() - base_n, exp_c.size()); end
    if (rq_cyc.size() > base_n) begin
      n_asrt++; if (rq_cyc[base_n] - (start_at - 1) != 13) begin
        n_fail++;
        $display("FAIL seq_first_latency: got %0d want 13",
                 rq_cyc[base_n] - (start_at - 1)); end
    end
    for (int k = 0; k < exp_c.size(); k++) begin
      if (base_n + k >= rq_cyc.size()) break;
      n_asrt++; if (rq_cyc[base_n+k] != exp_c[k]) begin n_fail++;
        $display("FAIL seq_req_cyc%0d: got %0d want %0d",
                 k, rq_cyc[base_n+k], exp_c[k]); end
      n_asrt++; if (rq_dat[base_n+k] !== exp_d[k]) begin n_fail++;
        $display("FAIL seq_data%0d: got %0h want %0h",
                 k, rq_dat[base_n+k], exp_d[k]); end
    end
    n_asrt++; if (cfg_done !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
    begin n_fail++;
      $display("FAIL seq_flags: cfg %b err %b busy %b want 1 0 0",
               cfg_done, err, busy); end
    n_asrt++; if (busy_fall != exp_end) begin n_fail++;
      $display("FAIL seq_end_cyc: got %0d want %0d",
               busy_fall, exp_end); end
    n_asrt++; if (hold_err != h0 || dbl_err != d0) begin n_fail++;
      $display("FAIL seq_hold: hold %0d dbl %0d want %0d %0d",
               hold_err, dbl_err, h0, d0); end
  endtask

  task automatic test_delay_entry();
    load_std();
    rom[1] = 15'h7F02;
    lat = 40;
    hold_ord = -1;
    launch();
    settle();
    n_asrt++; if (rq_cyc.size() - base_n != 2) begin n_fail++;
      $display("FAIL dly_count: got %0d want 2",
               rq_cyc.size() - base_n); end
    for (int k = 0; k < exp_c.size(); k++) begin
      if (base_n + k >= rq_cyc.size()) break;
      n_asrt++; if (rq_cyc[base_n+k] != exp_c[k]) begin n_fail++;
        $display("FAIL dly_req_cyc%0d: got %0d want %0d",
                 k, rq_cyc[base_n+k], exp_c[k]); end
      n_asrt++; if (rq_dat[base_n+k] !== exp_d[k]) begin n_fail++;
        $display("FAIL dly_data%0d: got %0h want %0h",
                 k, rq_dat[base_n+k], exp_d[k]); end
    end
    n_asrt++; if (cfg_done !== 1'b1 || busy_fall != exp_end) begin
      n_fail++;
      $display("FAIL dly_end: cfg %b end %0d want 1 %0d",
               cfg_done, busy_fall, exp_end); end
  endtask

  task automatic test_timeout();
    int n_end;
    load_std();
    lat = 40;
    hold_ord = 1;
    launch();
    settle();
    n_asrt++; if (rq_cyc.size() - base_n != 2) begin n_fail++;
      $display("FAIL tmo_count: got %0d want 2",
               rq_cyc.size() - base_n); end
    n_asrt++; if (err !== 1'b1 || cfg_done !== 1'b0 || busy !== 1'b0)
    begin n_fail++;
      $display("FAIL tmo_flags: err %b cfg %b busy %b want 1 0 0",
               err, cfg_done, busy); end
    n_asrt++; if (busy_fall != exp_end) begin n_fail++;
      $display("FAIL tmo_cyc: got %0d want %0d",
               busy_fall, exp_end); end
    if (rq_cyc.size() >= base_n + 2) begin
      n_asrt++; if (busy_fall - rq_cyc[base_n+1] != 255) begin
        n_fail++;
        $display("FAIL tmo_after_req: got %0d want 255",
                 busy_fall - rq_cyc[base_n+1]); end
    end
    n_end = rq_cyc.size();
    repeat (40) @(posedge clk);
    #2;
    n_asrt++; if (rq_cyc.size() != n_end || err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_quiet: reqs %0d err %b want %0d 1",
               rq_cyc.size(), err, n_end); end
    hold_ord = -1;
  endtask

  task automatic test_ignored();
    load_std();
    lat = 40;
    hold_ord = -1;
    launch();
    start_at2 = exp_c[0] + 10;
    xdone_at  = exp_c[0] + lat + 5;
    settle();
    n_asrt++; if (rq_cyc.size() - base_n != exp_c.size()) begin
      n_fail++;
      $display("FAIL ign_count: got %0d want %0d",
               rq_cyc.size() - base_n, exp_c.size()); end
    for (int k = 0; k < exp_c.size(); k++) begin
      if (base_n + k >= rq_cyc.size()) break;
      n_asrt++; if (rq_cyc[base_n+k] != exp_c[k] ||
                    rq_dat[base_n+k] !== exp_d[k]) begin n_fail++;
        $display("FAIL ign_req%0d: got %0d/%0h want %0d/%0h", k,
                 rq_cyc[base_n+k], rq_dat[base_n+k],
                 exp_c[k], exp_d[k]); end
    end
    n_asrt++; if (cfg_done !== 1'b1 || busy_fall != exp_end) begin
      n_fail++;
      $display("FAIL ign_end: cfg %b end %0d want 1 %0d",
               cfg_done, busy_fall, exp_end); end
  endtask

  task automatic test_reset_mid();
    int n_at;
    load_std();
    lat = 40;
    hold_ord = -1;
    launch();
    while (rq_cyc.size() - base_n < 2 && cyc < exp_c[1] + 5)
      @(posedge clk);
    n_asrt++; if (rq_cyc.size() - base_n < 2) begin n_fail++;
      $display("FAIL rmid_reach: reqs %0d want 2",
               rq_cyc.size() - base_n); end
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_asrt++; if ({rom_addr, data_tx, req, busy, cfg_done, err} !== '0)
    begin n_fail++;
      $display("FAIL rmid_zero: addr %0h tx %0h req %b busy %b cfg %b err %b want all 0",
               rom_addr, data_tx, req, busy, cfg_done, err); end
    n_at = rq_cyc.size();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (80) @(posedge clk);
    #2;
    n_asrt++; if (rq_cyc.size() != n_at || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_quiet: reqs %0d busy %b want %0d 0",
               rq_cyc.size(), busy, n_at); end
    launch();
    settle();
    n_asrt++; if (rq_cyc.size() - base_n != exp_c.size()) begin
      n_fail++;
      $display("FAIL rmid_count: got %0d want %0d",
               rq_cyc.size() - base_n, exp_c.size()); end
    for (int k = 0; k < exp_c.size(); k++) begin
      if (base_n + k >= rq_cyc.size()) break;
      n_asrt++; if (rq_cyc[base_n+k] != exp_c[k] ||
                    rq_dat[base_n+k] !== exp_d[k]) begin n_fail++;
        $display("FAIL rmid_req%0d: got %0d/%0h want %0d/%0h", k,
                 rq_cyc[base_n+k], rq_dat[base_n+k],
                 exp_c[k], exp_d[k]); end
    end
    n_asrt++; if (cfg_done !== 1'b1 || busy_fall != exp_end) begin
      n_fail++;
      $display("FAIL rmid_end: cfg %b end %0d want 1 %0d",
               cfg_done, busy_fall, exp_end); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(0, 3) == 0)
          rom[i] = {7'h7F, 7'd0, 1'($urandom_range(0, 1))};
        else
          rom[i] = {7'($urandom_range(0, 126)), 8'($urandom)};
      end
      lat = $urandom_range(2, 60);
      hold_ord = ($urandom_range(0, 3) == 0) ?
                 $urandom_range(0, NW - 1) : -1;
      launch();
      settle();
      n_asrt++; if (rq_cyc.size() - base_n != exp_c.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count: got %0d want %0d", it,
                 rq_cyc.size() - base_n, exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
        if (base_n + k >= rq_cyc.size()) break;
        n_asrt++; if (rq_cyc[base_n+k] != exp_c[k] ||
                      rq_dat[base_n+k] !== exp_d[k]) begin n_fail++;
          $display("FAIL rnd%0d_req%0d: got %0d/%0h want %0d/%0h",
                   it, k, rq_cyc[base_n+k], rq_dat[base_n+k],
                   exp_c[k], exp_d[k]); end
      end
      n_asrt++; if (cfg_done !== !exp_er || err !== exp_er ||
                    busy !== 1'b0) begin n_fail++;
        $display("FAIL rnd%0d_flags: cfg %b err %b busy %b want %b %b 0",
                 it, cfg_done, err, busy, !exp_er, exp_er); end
      n_asrt++; if (busy_fall != exp_end) begin n_fail++;
        $display("FAIL rnd%0d_end: got %0d want %0d",
                 it, busy_fall, exp_end); end
      n_asrt++; if (hold_err != h0 || dbl_err != d0) begin n_fail++;
        $display("FAIL rnd%0d_hold: hold %0d dbl %0d want %0d %0d",
                 it, hold_err, dbl_err, h0, d0); end
    end
    hold_ord = -1;
  endtask

  initial begin
    load_std();
    test_reset();
    test_spec_seq();
    test_delay_entry();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
